// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory time-slot arbiter.
// The phase bit indices match the signalizer's strobe ordering.
package mem_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam int PH_FETCH  = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_EXEC   = 2;
  localparam int PH_RDMEM  = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_EXT  = 2'd3
  } mem_owner_t;

  // True when exactly one phase strobe is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of phase strobes, CPU/external request ports and memory bus around
// the arbiter. The arbiter uses the slave view; its environment uses master.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              phase_fetch;
  logic              phase_decode;
  logic              phase_exec;
  logic              phase_rdmem;
  logic              cpu_halt;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              if_valid;
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_rd;
  logic              dm_wr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_rvalid;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              phase_err;

  modport slave (
    input  phase_fetch, phase_decode, phase_exec, phase_rdmem, cpu_halt,
    input  if_addr, dm_addr, dm_rd, dm_wr, dm_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
    output if_data, if_valid, dm_rdata, dm_rvalid,
    output ext_ack, ext_rdata, ext_rvalid,
    output mem_addr, mem_we, mem_wdata, phase_err
  );

  modport master (
    output phase_fetch, phase_decode, phase_exec, phase_rdmem, cpu_halt,
    output if_addr, dm_addr, dm_rd, dm_wr, dm_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
    input  if_data, if_valid, dm_rdata, dm_rvalid,
    input  ext_ack, ext_rdata, ext_rvalid,
    input  mem_addr, mem_we, mem_wdata, phase_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Time-slot arbiter for the single-port main memory: picks the slot owner each
// cycle and steers the one-cycle-latency read data back to whoever issued it.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input logic           clk_i,
  input logic           rst_ni,
  mem_arbiter_if.slave  bus
);

  logic [3:0]        phase_s;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              we_s;
  logic [DATA_W-1:0] wdata_s;
  logic              grant_ext_s;
  mem_owner_t        owner_d, owner_q;
  logic              phase_err_d, phase_err_q;

  // Slot decode: halt gives the external port every cycle, otherwise the
  // highest-priority strobe picks the slot (fetch > rdmem > exec > decode).
  always_comb begin
    phase_s              = 4'b0000;
    phase_s[PH_FETCH]    = bus.phase_fetch;
    phase_s[PH_DECODE]   = bus.phase_decode;
    phase_s[PH_EXEC]     = bus.phase_exec;
    phase_s[PH_RDMEM]    = bus.phase_rdmem;
    addr_d               = addr_q;
    we_s                 = 1'b0;
    wdata_s              = bus.dm_wdata;
    grant_ext_s          = 1'b0;
    owner_d              = OWN_NONE;
    phase_err_d          = phase_err_q;
    if (bus.cpu_halt) begin
      grant_ext_s = bus.ext_req;
    end else begin
      if (!is_onehot4(phase_s)) begin
        phase_err_d = 1'b1;
      end else begin
        phase_err_d = phase_err_q;
      end
      if (phase_s[PH_FETCH]) begin
        addr_d  = bus.if_addr;
        owner_d = OWN_IF;
      end else if (phase_s[PH_RDMEM]) begin
        if (bus.dm_rd) begin
          addr_d  = bus.dm_addr;
          owner_d = OWN_DM;
        end else begin
          owner_d = OWN_NONE;
        end
      end else if (phase_s[PH_EXEC]) begin
        if (bus.dm_wr) begin
          addr_d  = bus.dm_addr;
          we_s    = 1'b1;
          wdata_s = bus.dm_wdata;
        end else begin
          we_s = 1'b0;
        end
      end else if (phase_s[PH_DECODE]) begin
        grant_ext_s = bus.ext_req;
      end else begin
        owner_d = OWN_NONE;
      end
    end
    if (grant_ext_s) begin
      addr_d  = bus.ext_addr;
      we_s    = bus.ext_we;
      wdata_s = bus.ext_wdata;
      owner_d = bus.ext_we ? OWN_NONE : OWN_EXT;
    end else begin
      grant_ext_s = 1'b0;
    end
  end

  // Return-owner, sticky phase error and held address registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q     <= OWN_NONE;
      phase_err_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      owner_q     <= owner_d;
      phase_err_q <= phase_err_d;
      addr_q      <= addr_d;
    end
  end

  // Write enable and grant are suppressed while reset is held.
  assign bus.mem_addr   = addr_d;
  assign bus.mem_we     = we_s & rst_ni;
  assign bus.mem_wdata  = wdata_s;
  assign bus.ext_ack    = grant_ext_s & rst_ni;

  assign bus.if_valid   = rst_ni & (owner_q == OWN_IF);
  assign bus.dm_rvalid  = rst_ni & (owner_q == OWN_DM);
  assign bus.ext_rvalid = rst_ni & (owner_q == OWN_EXT);
  assign bus.if_data    = bus.mem_rdata;
  assign bus.dm_rdata   = bus.mem_rdata;
  assign bus.ext_rdata  = bus.mem_rdata;
  assign bus.phase_err  = phase_err_q;

endmodule
